swu_pad: RTL and testbench

Zero-padding stage placed directly upstream of the sliding window unit (`swu`). It accepts an unpadded IFM stream in raster order (row, column, channel fold) and inserts all-zero beats for the border of `PADDING_HEIGHT` rows top and bottom and `PADDING_WIDTH` columns left and right. The output is a padded frame that `swu` can consume with its own padding parameters set to 0. Frames are processed back to back indefinitely.

---
 rtl/swu_pad.sv | 101 ++++++++++
 tb/tb_swu_pad.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/swu_pad.sv
// Zero-padding stage ahead of the sliding window unit: inserts all-zero border
// beats around a raster-order IFM stream so swu can run with padding disabled.
module swu_pad #(
  parameter int unsigned SIMD           = 1,
  parameter int unsigned IP_PRECISION   = 8,
  parameter int unsigned IFMChannels    = 2,
  parameter int unsigned IFMWidth       = 6,
  parameter int unsigned IFMHeight      = 6,
  parameter int unsigned PADDING_WIDTH  = 1,
  parameter int unsigned PADDING_HEIGHT = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [SIMD*IP_PRECISION-1:0] ip_axis_tdata,
  input  logic                         ip_axis_tvalid,
  output logic                         ip_axis_tready,
  output logic [SIMD*IP_PRECISION-1:0] op_axis_tdata,
  output logic                         op_axis_tvalid,
  input  logic                         op_axis_tready
);

  localparam int unsigned DW   = SIMD * IP_PRECISION;
  localparam int unsigned FOLD = IFMChannels / SIMD;
  localparam int unsigned PW   = IFMWidth + 2 * PADDING_WIDTH;
  localparam int unsigned PH   = IFMHeight + 2 * PADDING_HEIGHT;
  localparam int unsigned FW   = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int unsigned CW   = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned RW   = (PH > 1) ? $clog2(PH) : 1;

  localparam logic [FW-1:0] FOLD_LAST = FW'(FOLD - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(PW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(PH - 1);

  logic [FW-1:0] r_fold;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [DW-1:0] r_tdata;
  logic          r_tvalid;

  logic w_row_pad;
  logic w_col_pad;
  logic w_pad;
  logic w_free;
  logic w_load;

  // Zero padding gets a constant-false term instead of an always-false compare.
  generate
    if (PADDING_HEIGHT > 0) begin : g_row_pad
      localparam logic [RW-1:0] ROW_TOP_END   = RW'(PADDING_HEIGHT);
      localparam logic [RW-1:0] ROW_BOT_START = RW'(PADDING_HEIGHT + IFMHeight);
      assign w_row_pad = (r_row < ROW_TOP_END) || (r_row >= ROW_BOT_START);
    end else begin : g_no_row_pad
      assign w_row_pad = 1'b0;
    end

    if (PADDING_WIDTH > 0) begin : g_col_pad
      localparam logic [CW-1:0] COL_LEFT_END    = CW'(PADDING_WIDTH);
      localparam logic [CW-1:0] COL_RIGHT_START = CW'(PADDING_WIDTH + IFMWidth);
      assign w_col_pad = (r_col < COL_LEFT_END) || (r_col >= COL_RIGHT_START);
    end else begin : g_no_col_pad
      assign w_col_pad = 1'b0;
    end
  endgenerate

  assign w_pad  = w_row_pad || w_col_pad;
  assign w_free = !r_tvalid || op_axis_tready;
  assign w_load = w_free && (w_pad || ip_axis_tvalid);

  assign ip_axis_tready = resetn && !w_pad && w_free;
  assign op_axis_tdata  = r_tdata;
  assign op_axis_tvalid = r_tvalid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_fold   <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      if (w_load) begin
        r_tdata  <= w_pad ? '0 : ip_axis_tdata;
        r_tvalid <= 1'b1;
        if (r_fold == FOLD_LAST) begin
          r_fold <= '0;
          if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end else begin
          r_fold <= r_fold + FW'(1);
        end
      end else if (r_tvalid && op_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_swu_pad.sv
// Directed bench for swu_pad: 4x4x2 frames with 1-pixel border, plus a
// zero-padding instance used as a plain pass-through register.
module tb_swu_pad;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] idat;
  logic       ivld;
  logic       ordy;
  logic       irdy, ovld;
  logic [7:0] odat;
  logic       irdy0, ovld0;
  logic [7:0] odat0;

  int n_checks = 0;
  int n_fail   = 0;
  int in_next  = 1;
  logic [7:0] outq[$];

  always #5 clk = ~clk;

  swu_pad #(
    .SIMD(1), .IP_PRECISION(8), .IFMChannels(2), .IFMWidth(4), .IFMHeight(4),
    .PADDING_WIDTH(1), .PADDING_HEIGHT(1)
  ) u_dut (
    .clk(clk), .resetn(rstn),
    .ip_axis_tdata(idat), .ip_axis_tvalid(ivld), .ip_axis_tready(irdy),
    .op_axis_tdata(odat), .op_axis_tvalid(ovld), .op_axis_tready(ordy)
  );

  swu_pad #(
    .SIMD(1), .IP_PRECISION(8), .IFMChannels(2), .IFMWidth(4), .IFMHeight(4),
    .PADDING_WIDTH(0), .PADDING_HEIGHT(0)
  ) u_dut0 (
    .clk(clk), .resetn(rstn),
    .ip_axis_tdata(idat), .ip_axis_tvalid(ivld), .ip_axis_tready(irdy0),
    .op_axis_tdata(odat0), .op_axis_tvalid(ovld0), .op_axis_tready(ordy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beat k (counted from the first frame start) of the padded stream,
  // when the first interior byte is first_byte and input bytes count upward.
  function automatic int exp_beat(input int k, input int first_byte);
    int f, c, r, frame;
    frame = k / 72;
    f = k % 2;
    c = (k / 2) % 6;
    r = (k / 12) % 6;
    if (r < 1 || r > 4 || c < 1 || c > 4) return 0;
    return (first_byte + 32 * frame + ((r - 1) * 4 + (c - 1)) * 2 + f) & 8'hff;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    ivld = 1'b0;
    idat = '0;
    ordy = 1'b1;
    #1;
    check("rst_irdy", irdy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_vld", ovld, 0);
    check("rst_dat", odat, 0);
    check("rst_irdy_low", irdy, 0);
    rstn = 1'b1;
  endtask

  // Streams counting input bytes and collects accepted output beats into outq.
  task automatic run_frames(input int n_beats, input int first_byte, input bit tog,
                            output int cyc);
    int budget;
    int gaps;
    budget = n_beats * 4 + 40;
    gaps   = 0;
    cyc    = 0;
    outq.delete();
    while (outq.size() < n_beats && cyc < budget) begin
      ordy = tog ? (cyc % 2 == 0) : 1'b1;
      ivld = 1'b1;
      idat = in_next[7:0];
      #1;
      if (ovld) check("data", {24'h0, odat}, exp_beat(outq.size(), first_byte));
      else if (outq.size() > 0) gaps++;
      if (ovld && !ordy) check("stall_irdy", irdy, 0);
      if (ovld && ordy) outq.push_back(odat);
      if (ivld && irdy) in_next++;
      @(posedge clk); #1;
      cyc++;
    end
    check("beats", outq.size(), n_beats);
    check("gaps", gaps, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int s5_first;
    int hs_prev;
    int hs;

    // 1: one frame at full rate
    do_reset();
    in_next = 1;
    run_frames(72, 1, 1'b0, cyc);
    check("s1_cycles", cyc, 73);
    if (outq.size() == 72) begin
      check("s1_b0", outq[0], 8'h00);
      check("s1_b13", outq[13], 8'h00);
      check("s1_b14", outq[14], 8'h01);
      check("s1_b21", outq[21], 8'h08);
      check("s1_b22", outq[22], 8'h00);
      check("s1_b23", outq[23], 8'h00);
      check("s1_b57", outq[57], 8'h20);
      check("s1_b58", outq[58], 8'h00);
      check("s1_b71", outq[71], 8'h00);
    end
    check("s1_consumed", in_next, 33);

    // 2: no input -> only the top border and the first left pad column
    do_reset();
    ivld = 1'b0;
    ordy = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ovld) begin
        check("s2_zero", odat, 8'h00);
        n++;
      end
      @(posedge clk); #1;
    end
    check("s2_beats", n, 14);
    check("s2_vld", ovld, 0);
    check("s2_irdy", irdy, 1);

    // 3: output ready toggling every cycle
    do_reset();
    in_next = 1;
    run_frames(72, 1, 1'b1, cyc);
    if (outq.size() == 72) begin
      check("s3_b14", outq[14], 8'h01);
      check("s3_b57", outq[57], 8'h20);
    end

    // 4: two frames back to back
    do_reset();
    in_next = 1;
    run_frames(144, 1, 1'b0, cyc);
    check("s4_cycles", cyc, 145);
    if (outq.size() == 144) begin
      check("s4_f2_b0", outq[72], 8'h00);
      check("s4_f2_b13", outq[85], 8'h00);
      check("s4_f2_b14", outq[86], 8'h21);
      check("s4_f2_b57", outq[129], 8'h40);
    end

    // 5: reset pulse mid-frame
    do_reset();
    in_next = 1;
    run_frames(31, 1, 1'b0, cyc);
    rstn = 1'b0;
    ivld = 1'b0;
    ordy = 1'b1;
    #1;
    check("s5_irdy_in_rst", irdy, 0);
    @(posedge clk); #1;
    check("s5_vld_after_rst", ovld, 0);
    check("s5_dat_after_rst", odat, 0);
    rstn = 1'b1;
    s5_first = in_next;
    check("s5_resume_byte", s5_first, 15);
    run_frames(15, s5_first, 1'b0, cyc);
    if (outq.size() == 15) begin
      check("s5_b13", outq[13], 8'h00);
      check("s5_b14", outq[14], 8'h0f);
    end

    // 6: zero-padding instance as a pass-through register
    do_reset();
    check("s6_rst_vld", ovld0, 0);
    in_next = 1;
    n = 0;
    cyc = 0;
    hs_prev = 0;
    while (n < 32 && cyc < 200) begin
      ordy = (cyc % 4 != 3);
      ivld = (in_next <= 32);
      idat = in_next[7:0];
      #1;
      if (hs_prev != 0) check("s6_latency", ovld0, 1);
      if (ovld0) begin
        check("s6_irdy", irdy0, ordy);
        check("s6_data", odat0, n + 1);
        if (ordy) n++;
      end
      hs = (ivld && irdy0) ? 1 : 0;
      if (hs != 0) in_next++;
      hs_prev = hs;
      @(posedge clk); #1;
      cyc++;
    end
    check("s6_beats", n, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
